// File: rtl/pipe_buffer.sv
// ---------------------------------------------------------------------------
// pipe_buffer
// Small circular FIFO between instruction fetch and decode. It holds
// {PC+4, instruction} pairs, presents the head entry to decode with a
// one-cycle latency, and drives a NOP bubble (all zeros) whenever it is empty.
// A flush discards every held entry. The number of entries discarded by
// flushes is accumulated in a saturating drop counter.
//
// Ports
//   clk_i       : clock; all state changes on its rising edge
//   rst_n_i     : synchronous active-low reset
//   in_valid_i  : fetch offers an entry
//   in_ready_o  : the buffer has room; decoded from registered occupancy only
//   pc_i        : PC+4 of the offered entry
//   instr_i     : instruction of the offered entry
//   flush_i     : discard all held entries; has priority over push and pop
//   out_valid_o : the head entry is valid
//   out_ready_i : decode consumes the head (low = stall)
//   pc_o        : head PC+4, or 0 when empty
//   instr_o     : head instruction, or 0 when empty
//   count_o     : number of occupied entries
//   drop_cnt_o  : cumulative entries discarded by flush (saturating)
// ---------------------------------------------------------------------------
module pipe_buffer #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 2,
  parameter int CNT_W   = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [PC_W-1:0]          pc_i,
  input  logic [INSTR_W-1:0]       instr_i,
  input  logic                     flush_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [PC_W-1:0]          pc_o,
  output logic [INSTR_W-1:0]       instr_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [CNT_W-1:0]         drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PC_W + INSTR_W;
  // The saturating sum must be wide enough for both the drop counter and the
  // occupancy count, plus a carry bit to detect overflow.
  localparam int SW = ((CNT_W > CW) ? CNT_W : CW) + 1;

  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [SW-1:0] DROP_MAX_C = {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [EW-1:0]    mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, wr_ptr_nxt_s;
  logic [AW-1:0]    rd_ptr_r, rd_ptr_nxt_s;
  logic [CW-1:0]    count_r, count_nxt_s;
  logic [CNT_W-1:0] drop_r, drop_nxt_s;
  logic [SW-1:0]    drop_sum_s;
  logic [EW-1:0]    head_s;
  logic             push_s;
  logic             pop_s;

  // Handshake flags, all derived from registered occupancy.
  assign in_ready_o  = (count_r < DEPTH_C);
  assign out_valid_o = (count_r != {CW{1'b0}});
  assign push_s      = in_valid_i & in_ready_o & ~flush_i;
  assign pop_s       = out_valid_o & out_ready_i & ~flush_i;
  assign count_o     = count_r;
  assign drop_cnt_o  = drop_r;

  // Next-state for pointers, occupancy and the saturating drop counter.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    drop_nxt_s   = drop_r;
    drop_sum_s   = SW'(drop_r) + SW'(count_r);

    if (flush_i) begin
      wr_ptr_nxt_s = {AW{1'b0}};
      rd_ptr_nxt_s = {AW{1'b0}};
      count_nxt_s  = {CW{1'b0}};
      if (drop_sum_s > DROP_MAX_C) begin
        drop_nxt_s = {CNT_W{1'b1}};
      end else begin
        drop_nxt_s = drop_sum_s[CNT_W-1:0];
      end
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_nxt_s = count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      drop_r   <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      drop_r   <= drop_nxt_s;
    end
  end

  // Entry storage; no reset, contents are masked while the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && push_s) begin
      mem_r[wr_ptr_r] <= {pc_i, instr_i};
    end
  end

  // Head entry, or a NOP bubble when nothing is held.
  always_comb begin
    head_s  = mem_r[rd_ptr_r];
    pc_o    = {PC_W{1'b0}};
    instr_o = {INSTR_W{1'b0}};
    if (out_valid_o) begin
      pc_o    = head_s[EW-1:INSTR_W];
      instr_o = head_s[INSTR_W-1:0];
    end else begin
      pc_o    = {PC_W{1'b0}};
      instr_o = {INSTR_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_pipe_buffer.sv
// ---------------------------------------------------------------------------
// tb_pipe_buffer
// Scoreboard bench for pipe_buffer (DEPTH=4, CNT_W=3). The driver applies
// directed scenarios then random traffic and keeps a queue model of the held
// entries; a negedge monitor compares the DUT outputs against that model and
// pops the queue on each consumed entry.
// ---------------------------------------------------------------------------
module tb_pipe_buffer;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 3;
  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int DROP_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    pc_in;
  logic [INSTR_W-1:0] instr_in;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    pc_out;
  logic [INSTR_W-1:0] instr_out;
  logic [CW-1:0]      count;
  logic [CNT_W-1:0]   drop_cnt;

  always #5 clk = ~clk;

  pipe_buffer #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .pc_i(pc_in), .instr_i(instr_in), .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .pc_o(pc_out), .instr_o(instr_out),
    .count_o(count), .drop_cnt_o(drop_cnt)
  );

  // Reference model: held entries in order, plus the drop total.
  logic [63:0] exp_q[$];
  int          mdl_drop;
  int          total;
  int          bad;
  bit          started;
  bit          pend_push, pend_flush, pend_rst;
  logic [63:0] pend_ent;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, predict the edge, then update the model.
  task automatic step(input bit rst, input bit v, input logic [31:0] pc,
                      input logic [31:0] ins, input bit fl, input bit ordy);
    rst_n     = ~rst;
    in_valid  = v;
    pc_in     = pc;
    instr_in  = ins;
    flush     = fl;
    out_ready = ordy;
    pend_rst   = rst;
    pend_flush = fl;
    pend_push  = v && (exp_q.size() < DEPTH) && !fl && !rst;
    pend_ent   = {pc, ins};
    @(posedge clk);
    #1;
    if (pend_rst) begin
      exp_q.delete();
      mdl_drop = 0;
    end else if (pend_flush) begin
      mdl_drop = mdl_drop + exp_q.size();
      if (mdl_drop > DROP_MAX) mdl_drop = DROP_MAX;
      exp_q.delete();
    end else if (pend_push) begin
      exp_q.push_back(pend_ent);
    end
  endtask

  // Monitor: compare state and head; consume the head on a handshake.
  int n;
  always @(negedge clk) begin
    if (started) begin
      n = exp_q.size();
      check("count", longint'(count), longint'(n));
      check("out_valid", longint'(out_valid), longint'(n != 0));
      check("in_ready", longint'(in_ready), longint'(n < DEPTH));
      check("drop_cnt", longint'(drop_cnt), longint'(mdl_drop));
      if (n == 0) begin
        check("bubble_pc", longint'(pc_out), 64'd0);
        check("bubble_instr", longint'(instr_out), 64'd0);
      end else if (out_valid) begin
        check("head_pc", longint'(pc_out), longint'(exp_q[0][63:32]));
        check("head_instr", longint'(instr_out), longint'(exp_q[0][31:0]));
        if (rst_n && out_ready && !flush) begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  int idx;

  initial begin
    total = 0; bad = 0; mdl_drop = 0; started = 1'b0;
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    started = 1'b1;
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

    // Single pass with one-cycle latency, then a bubble.
    step(1'b0, 1'b1, 32'd4, 32'h2008_0005, 1'b0, 1'b1);
    check("single_pc", longint'(pc_out), 64'd4);
    check("single_instr", longint'(instr_out), 64'h2008_0005);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    check("single_after", longint'(out_valid), 64'd0);

    // Stall fill: one offer beyond capacity is refused, then drain in order.
    for (int i = 1; i <= DEPTH + 1; i++)
      step(1'b0, 1'b1, 32'(4 * i), 32'(i), 1'b0, 1'b0);
    check("full_ready", longint'(in_ready), 64'd0);
    for (int i = 0; i < DEPTH + 1; i++)
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

    // Flush two held entries while offering pc=16.
    step(1'b0, 1'b1, 32'd4, 32'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'd8, 32'd2, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'd16, 32'd3, 1'b1, 1'b0);
    check("flush_drop", longint'(drop_cnt), 64'd2);
    check("flush_count", longint'(count), 64'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);  // flush while empty

    // Wrap: stream 10 entries with out_ready toggling.
    idx = 1;
    for (int c = 0; c < 80 && idx <= 10; c++) begin
      step(1'b0, 1'b1, 32'(4 * idx), 32'(idx + 100), 1'b0, c[0]);
      if (pend_push) idx++;
    end
    check("wrap_all_sent", longint'(idx), 64'd11);
    for (int i = 0; i < DEPTH + 1; i++)
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

    // Saturation: full-buffer flushes push drop past its maximum.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < DEPTH; i++)
        step(1'b0, 1'b1, 32'(i * 4 + 200), 32'(f), 1'b0, 1'b0);
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    end
    check("sat_drop", longint'(drop_cnt), longint'(DROP_MAX));

    // Reset mid-operation with flush also asserted.
    step(1'b0, 1'b1, 32'd4, 32'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'd8, 32'd2, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'd12, 32'd3, 1'b1, 1'b1);
    check("rst_drop", longint'(drop_cnt), 64'd0);
    check("rst_ready", longint'(in_ready), 64'd1);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      step(($urandom % 80) == 0, ($urandom % 4) != 0, $urandom, $urandom,
           ($urandom % 15) == 0, ($urandom % 3) != 0);
    end

    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
